rs232_rx_ctrl: RTL and testbench

Controller that sits between the rs232_rx receiver and the consumer logic. It owns the receiver configuration (baud divisor, parity select) and changes it only when the line is idle. It tracks frame activity with a timeout watchdog and buffers each received byte plus its parity status in a small FIFO. It flags overrun and timeout conditions and keeps a saturating count of parity errors.

---
 rtl/rs232_pkg.sv | 24 ++
 rtl/rx_fifo.sv | 57 +++++
 rtl/rs232_rx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rs232_rx_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared constants, FSM encoding and FIFO payload type for the rs232 receive controller.
package rs232_pkg;

  localparam int unsigned BAUD_W        = 15;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned CLK_HZ        = 100_000_000;
  localparam int unsigned TICKS_PER_BIT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic              perr;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  // Divisor for a given baud rate: the prescaler counts 0..div, TICKS_PER_BIT ticks per bit.
  function automatic logic [BAUD_W-1:0] baud_div(input int unsigned baud);
    return BAUD_W'(CLK_HZ / (TICKS_PER_BIT * baud) - 1);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through FIFO of received bytes with their parity flag.
module rx_fifo
  import rs232_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  rx_entry_t              din,
  output rx_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  rx_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_pop;
  logic            do_push;

  // A pop on an empty FIFO is ignored; a full FIFO accepts a push only alongside a pop.
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = count;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/rs232_rx_ctrl.sv
// Receive controller: owns baud/parity config, watches frame activity with a
// timeout, buffers received bytes and keeps overrun/timeout/parity status.
module rs232_rx_ctrl
  import rs232_pkg::*;
#(
  parameter int unsigned       DEPTH       = 4,
  parameter logic [BAUD_W-1:0] BAUD_RST    = 15'd2603,
  parameter int unsigned       FRAME_TICKS = 48
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_i,
  input  logic                   eor_i,
  input  logic [DATA_W-1:0]      dout_i,
  input  logic                   pcheck_i,
  output logic [BAUD_W-1:0]      baud_o,
  output logic                   psel_o,
  input  logic                   cfg_we_i,
  input  logic [BAUD_W-1:0]      cfg_baud_i,
  input  logic                   cfg_psel_i,
  output logic                   cfg_pend_o,
  output logic                   busy_o,
  input  logic                   rd_i,
  output logic                   valid_o,
  output logic [DATA_W-1:0]      data_o,
  output logic                   perr_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   ovf_o,
  output logic                   tmo_o,
  output logic [7:0]             perr_cnt_o,
  input  logic                   clr_i
);

  localparam int unsigned TW = $clog2(FRAME_TICKS + 1);

  state_t            state;
  logic              rx_s1;
  logic              rx_s2;
  logic              rx_s3;
  logic [BAUD_W-1:0] presc;
  logic [TW-1:0]     ticks;
  logic [BAUD_W-1:0] pend_baud;
  logic              pend_psel;
  rx_entry_t         push_entry;
  rx_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fall_c;
  logic              tick_c;
  logic              frame_tmo_c;
  logic              apply_c;
  logic              ovf_set_c;

  assign fall_c      = rx_s3 & ~rx_s2;
  assign tick_c      = (state == BUSY) && (presc == baud_o);
  // eor_i in the final tick cycle completes the frame rather than timing it out.
  assign frame_tmo_c = tick_c && (ticks == TW'(FRAME_TICKS - 1)) && !eor_i;
  assign apply_c     = (state == IDLE) && cfg_pend_o;
  assign ovf_set_c   = eor_i && fifo_full && !(rd_i && valid_o);
  assign push_entry  = '{perr: pcheck_i & psel_o, data: dout_i};

  assign busy_o  = (state == BUSY);
  assign valid_o = !fifo_empty;
  assign data_o  = head.data;
  assign perr_o  = head.perr;

  // Line synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Frame FSM with prescaler and baud tick counter for the watchdog.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      presc <= '0;
      ticks <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall_c) begin
            state <= BUSY;
            presc <= '0;
            ticks <= '0;
          end
        end
        BUSY: begin
          if (eor_i || frame_tmo_c) begin
            state <= IDLE;
          end else if (tick_c) begin
            presc <= '0;
            ticks <= ticks + TW'(1);
          end else begin
            presc <= presc + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pending configuration is applied only while idle; the latest write wins.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      baud_o     <= BAUD_RST;
      psel_o     <= 1'b0;
      pend_baud  <= '0;
      pend_psel  <= 1'b0;
      cfg_pend_o <= 1'b0;
    end else begin
      if (cfg_we_i) begin
        pend_baud  <= cfg_baud_i;
        pend_psel  <= cfg_psel_i;
        cfg_pend_o <= 1'b1;
      end else if (apply_c) begin
        cfg_pend_o <= 1'b0;
      end
      if (apply_c) begin
        baud_o <= pend_baud;
        psel_o <= pend_psel;
      end
    end
  end

  // Sticky status; clr_i wins over any same-cycle set or increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_o      <= 1'b0;
      tmo_o      <= 1'b0;
      perr_cnt_o <= '0;
    end else if (clr_i) begin
      ovf_o      <= 1'b0;
      tmo_o      <= 1'b0;
      perr_cnt_o <= '0;
    end else begin
      if (ovf_set_c) begin
        ovf_o <= 1'b1;
      end
      if (frame_tmo_c) begin
        tmo_o <= 1'b1;
      end
      if (eor_i && push_entry.perr && (perr_cnt_o != 8'hFF)) begin
        perr_cnt_o <= perr_cnt_o + 8'd1;
      end
    end
  end

  rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (eor_i),
    .pop   (rd_i),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// Bench for rs232_rx_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model.
module tb_rs232_rx_ctrl;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned FRAME_TICKS = 48;

  logic        clk_i      = 1'b0;
  logic        rst_i      = 1'b0;
  logic        rx_i       = 1'b1;
  logic        eor_i      = 1'b0;
  logic [7:0]  dout_i     = 8'h00;
  logic        pcheck_i   = 1'b0;
  logic        cfg_we_i   = 1'b0;
  logic [14:0] cfg_baud_i = 15'd0;
  logic        cfg_psel_i = 1'b0;
  logic        rd_i       = 1'b0;
  logic        clr_i      = 1'b0;
  logic [14:0] baud_o;
  logic        psel_o;
  logic        cfg_pend_o;
  logic        busy_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        perr_o;
  logic [2:0]  level_o;
  logic        ovf_o;
  logic        tmo_o;
  logic [7:0]  perr_cnt_o;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  rs232_rx_ctrl #(
    .DEPTH       (DEPTH),
    .BAUD_RST    (15'd2603),
    .FRAME_TICKS (FRAME_TICKS)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .eor_i      (eor_i),
    .dout_i     (dout_i),
    .pcheck_i   (pcheck_i),
    .baud_o     (baud_o),
    .psel_o     (psel_o),
    .cfg_we_i   (cfg_we_i),
    .cfg_baud_i (cfg_baud_i),
    .cfg_psel_i (cfg_psel_i),
    .cfg_pend_o (cfg_pend_o),
    .busy_o     (busy_o),
    .rd_i       (rd_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .perr_o     (perr_o),
    .level_o    (level_o),
    .ovf_o      (ovf_o),
    .tmo_o      (tmo_o),
    .perr_cnt_o (perr_cnt_o),
    .clr_i      (clr_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [8:0] mq[$];
  int         m_baud  = 2603;
  bit         m_psel  = 1'b0;
  bit         m_pend  = 1'b0;
  int         m_pbaud = 0;
  bit         m_ppsel = 1'b0;
  bit         m_busy  = 1'b0;
  longint     m_start = 0;
  longint     ncyc    = 0;
  bit         m_ovf   = 1'b0;
  bit         m_tmo   = 1'b0;
  int         m_cnt   = 0;
  bit [3:0]   hist    = 4'hF;
  bit         mv_apply, mv_fall, mv_tmo, mv_psel, mv_ppsel;
  int         mv_pbaud;
  logic [8:0] mv_ent, mv_drop;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mq.delete();
      m_baud = 2603; m_psel = 1'b0; m_pend = 1'b0; m_pbaud = 0; m_ppsel = 1'b0;
      m_busy = 1'b0; m_start = 0; ncyc = 0;
      m_ovf = 1'b0; m_tmo = 1'b0; m_cnt = 0; hist = 4'hF;
    end else begin
      ncyc++;
      // Line is seen through two sync stages plus an edge detector.
      hist     = {hist[2:0], rx_i};
      mv_fall  = hist[3] && !hist[2];
      mv_apply = !m_busy && m_pend;
      mv_pbaud = m_pbaud;
      mv_ppsel = m_ppsel;
      mv_psel  = m_psel;
      mv_tmo   = 1'b0;
      if (!m_busy) begin
        if (mv_fall) begin
          m_busy  = 1'b1;
          m_start = ncyc;
        end
      end else if (eor_i) begin
        m_busy = 1'b0;
      end else if (ncyc - m_start == longint'(FRAME_TICKS) * longint'(m_baud + 1)) begin
        m_busy = 1'b0;
        mv_tmo = 1'b1;
      end
      if (cfg_we_i) begin
        m_pend = 1'b1; m_pbaud = int'(cfg_baud_i); m_ppsel = cfg_psel_i;
      end else if (mv_apply) begin
        m_pend = 1'b0;
      end
      if (mv_apply) begin
        m_baud = mv_pbaud; m_psel = mv_ppsel;
      end
      if (rd_i && mq.size() > 0) mv_drop = mq.pop_front();
      if (eor_i) begin
        mv_ent = {pcheck_i & mv_psel, dout_i};
        if (mv_ent[8] && m_cnt < 255) m_cnt++;
        if (mq.size() < DEPTH) mq.push_back(mv_ent);
        else m_ovf = 1'b1;
      end
      if (mv_tmo) m_tmo = 1'b1;
      if (clr_i) begin
        m_ovf = 1'b0; m_tmo = 1'b0; m_cnt = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk_i) begin
    chk("baud", longint'(baud_o), longint'(m_baud));
    chk("psel", longint'(psel_o), longint'(m_psel));
    chk("cfg_pend", longint'(cfg_pend_o), longint'(m_pend));
    chk("busy", longint'(busy_o), longint'(m_busy));
    chk("valid", longint'(valid_o), longint'(mq.size() != 0));
    chk("level", longint'(level_o), longint'(mq.size()));
    chk("ovf", longint'(ovf_o), longint'(m_ovf));
    chk("tmo", longint'(tmo_o), longint'(m_tmo));
    chk("perr_cnt", longint'(perr_cnt_o), longint'(m_cnt));
    if (mq.size() > 0) begin
      chk("data", longint'(data_o), longint'(mq[0][7:0]));
      chk("perr", longint'(perr_o), longint'(mq[0][8]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cfg_write(input int b, input bit p);
    cfg_baud_i = 15'(b); cfg_psel_i = p; cfg_we_i = 1'b1;
    tick(1);
    cfg_we_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input bit pc, input bit rd);
    dout_i = d; pcheck_i = pc; eor_i = 1'b1; rd_i = rd;
    tick(1);
    eor_i = 1'b0; rd_i = 1'b0; pcheck_i = 1'b0;
  endtask

  task automatic pop1();
    rd_i = 1'b1;
    tick(1);
    rd_i = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy_o === lvl) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  initial begin
    bit     ok;
    longint t0;
    longint t1;
    tick(4);
    rst_i = 1'b1;
    tick(2);
    chk("rst_baud", longint'(baud_o), 2603);
    chk("rst_data", longint'(data_o), 0);
    chk("rst_level", longint'(level_o), 0);

    // Reset in the middle of a frame with a byte already buffered.
    push(8'h11, 1'b0, 1'b0);
    rx_i = 1'b0;
    tick(2);
    chk("busy_early", longint'(busy_o), 0);
    tick(1);
    chk("busy_3cyc", longint'(busy_o), 1);
    #3 rst_i = 1'b0;
    #1;
    chk("midrst_level", longint'(level_o), 0);
    chk("midrst_busy", longint'(busy_o), 0);
    chk("midrst_baud", longint'(baud_o), 2603);
    rx_i = 1'b1;
    tick(2);
    rst_i = 1'b1;
    tick(2);

    // Config applied two edges after an idle write.
    cfg_write(1301, 1'b1);
    chk("cfg_pend_set", longint'(cfg_pend_o), 1);
    chk("cfg_not_yet", longint'(baud_o), 2603);
    tick(1);
    chk("cfg_baud", longint'(baud_o), 1301);
    chk("cfg_psel", longint'(psel_o), 1);
    chk("cfg_pend_clr", longint'(cfg_pend_o), 0);

    // Deferred config across a frame; second of two writes wins.
    cfg_write(2603, 1'b0);
    tick(1);
    rx_i = 1'b0;
    tick(3);
    rx_i = 1'b1;
    chk("frame_busy", longint'(busy_o), 1);
    cfg_write(100, 1'b0);
    cfg_write(650, 1'b0);
    tick(5);
    chk("defer_baud", longint'(baud_o), 2603);
    chk("defer_pend", longint'(cfg_pend_o), 1);
    push(8'hAA, 1'b1, 1'b0);
    chk("frame_done", longint'(busy_o), 0);
    chk("aa_valid", longint'(valid_o), 1);
    chk("aa_data", longint'(data_o), 170);
    chk("aa_perr", longint'(perr_o), 0);
    chk("aa_level", longint'(level_o), 1);
    tick(1);
    chk("defer_apply", longint'(baud_o), 650);
    pop1();
    chk("aa_popped", longint'(valid_o), 0);

    // Timeout at divisor 650: 48 * 651 cycles from busy rising.
    rx_i = 1'b0;
    tick(1);
    rx_i = 1'b1;
    wait_busy(1'b1, 10, ok);
    chk("tmo_start", longint'(ok), 1);
    t0 = cyc;
    wait_busy(1'b0, 40000, ok);
    chk("tmo_end", longint'(ok), 1);
    t1 = cyc;
    chk("tmo_len", t1 - t0, 31248);
    chk("tmo_flag", longint'(tmo_o), 1);
    chk("tmo_level", longint'(level_o), 0);
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    chk("tmo_clr", longint'(tmo_o), 0);

    // Parity errors saturate the counter.
    cfg_write(5, 1'b1);
    tick(1);
    push(8'h55, 1'b1, 1'b0);
    chk("p_perr", longint'(perr_o), 1);
    chk("p_cnt1", longint'(perr_cnt_o), 1);
    chk("p_data", longint'(data_o), 85);
    pop1();
    for (int i = 0; i < 299; i++) begin
      push(8'(i), 1'b1, 1'b0);
      pop1();
    end
    chk("p_sat", longint'(perr_cnt_o), 255);
    dout_i = 8'h01; pcheck_i = 1'b1; eor_i = 1'b1; clr_i = 1'b1;
    tick(1);
    eor_i = 1'b0; clr_i = 1'b0; pcheck_i = 1'b0;
    chk("p_clr_prio", longint'(perr_cnt_o), 0);
    pop1();

    // Overflow, order, push+pop while full.
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b0, 1'b0);
    chk("ovf_level", longint'(level_o), 4);
    chk("ovf_flag", longint'(ovf_o), 1);
    chk("ovf_head", longint'(data_o), 1);
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    push(8'h06, 1'b0, 1'b1);
    chk("full_pp_level", longint'(level_o), 4);
    chk("full_pp_ovf", longint'(ovf_o), 0);
    chk("order_0", longint'(data_o), 2); pop1();
    chk("order_1", longint'(data_o), 3); pop1();
    chk("order_2", longint'(data_o), 4); pop1();
    chk("order_3", longint'(data_o), 6); pop1();
    chk("drained", longint'(valid_o), 0);

    // Random traffic with small divisors so watchdogs expire often.
    cfg_write(3, 1'b0);
    tick(2);
    for (int i = 0; i < 5000; i++) begin
      rx_i     = ($urandom_range(0, 9) != 0);
      eor_i    = ($urandom_range(0, 11) == 0);
      dout_i   = 8'($urandom_range(0, 255));
      pcheck_i = 1'($urandom_range(0, 1));
      rd_i     = ($urandom_range(0, 3) == 0);
      clr_i    = ($urandom_range(0, 199) == 0);
      cfg_we_i = ($urandom_range(0, 49) == 0);
      cfg_baud_i = 15'($urandom_range(0, 7));
      cfg_psel_i = 1'($urandom_range(0, 1));
      tick(1);
    end
    rx_i = 1'b1; eor_i = 1'b0; rd_i = 1'b0; clr_i = 1'b0; cfg_we_i = 1'b0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
